// File: rtl/mult_booth_if.sv
// mult_booth_if
//   Request/result bundle between the datapath control and the Booth
//   multiplier.
//   master : drives start/a_in/b_in, observes busy/done/hi/lo
//   slave  : the multiplier side
//   start  - request a multiply (honoured only while the multiplier is idle)
//   a_in   - multiplicand, signed two's complement
//   b_in   - multiplier, signed two's complement
//   busy   - operation in progress (RUN or DONE)
//   done   - one-cycle completion pulse; hi/lo valid from this cycle
//   hi/lo  - upper/lower half of the signed 2*WIDTH-bit product
interface mult_booth_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a_in, b_in,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_booth.sv
// mult_booth
//   Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth.
//   One Booth step per clock; WIDTH steps per product.
//   Ports:
//     clk     - clock, all state on the rising edge
//     reset_n - asynchronous active-low reset
//     bus     - mult_booth_if slave (start, a_in, b_in, busy, done, hi, lo)
//   Timing: start sampled at edge E0, done high in the cycle after edge
//   E0+WIDTH, then back to IDLE. hi/lo hold until the next completion.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mult_booth_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] m_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   acc_reg;    // one guard bit so M = -2^(WIDTH-1) cannot overflow
  logic             qm1_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_shift;
  logic [WIDTH-1:0] q_shift;
  logic             last_step;

  // Booth step: add/subtract sign-extended M according to {Q[0], q_m1}.
  assign m_ext = {m_reg[WIDTH-1], m_reg};

  always_comb begin
    sum = acc_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   sum = acc_reg + m_ext;
      2'b10:   sum = acc_reg - m_ext;
      default: sum = acc_reg;
    endcase
  end

  // Arithmetic right shift of {ACC, Q, q_m1}; ACC MSB replicated.
  assign acc_shift = {sum[WIDTH], sum[WIDTH:1]};
  assign q_shift   = {sum[0], q_reg[WIDTH-1:1]};

  assign last_step = (count_reg == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg     <= '0;
      q_reg     <= '0;
      acc_reg   <= '0;
      qm1_reg   <= 1'b0;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            m_reg     <= bus.a_in;
            q_reg     <= bus.b_in;
            acc_reg   <= '0;
            qm1_reg   <= 1'b0;
            count_reg <= '0;
          end
        end
        RUN: begin
          acc_reg   <= acc_shift;
          q_reg     <= q_shift;
          qm1_reg   <= q_reg[0];
          count_reg <= count_reg + CW'(1);
          // Final step: product is {ACC[WIDTH-1:0], Q} after this shift
          if (last_step) begin
            hi_reg <= acc_shift[WIDTH-1:0];
            lo_reg <= q_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN) || (state_reg == DONE);
  assign bus.done = (state_reg == DONE);
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule
